// File: rtl/symbol_packer_pkg.sv
// Shared constants and helpers for the symbol strobe packer.
// Mode encodings and a constant-time clog2 used for FIFO sizing.
package symbol_packer_pkg;

   localparam logic MODE_STROBE = 1'b0;
   localparam logic MODE_DECIM  = 1'b1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/symbol_packer_fifo.sv
// First-word-fall-through FIFO: registered write, data visible the cycle after write.
// Writes are dropped when full (even with a same-cycle read); clear empties it synchronously.
module symbol_packer_fifo
   import symbol_packer_pkg::*;
#(
   parameter int DW    = 33,
   parameter int DEPTH = 16
) (
   input  logic                    ce_clk,
   input  logic                    ce_rst,
   input  logic                    clear_i,
   input  logic                    wr_en_i,
   input  logic [DW-1:0]           wr_dat_i,
   input  logic                    rd_en_i,
   output logic [DW-1:0]           rd_dat_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [clog2(DEPTH):0]   level_o
);

   localparam int AW = clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   level_q;
   logic          do_wr;
   logic          do_rd;

   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign do_wr   = wr_en_i & ~full_o & ~clear_i;
   assign do_rd   = rd_en_i & ~empty_o & ~clear_i;

   // Gate the read word so the output bus reads zero whenever nothing is queued.
   assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end

   always_ff @(posedge ce_clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
   end

endmodule

// File: rtl/symbol_strobe_packer.sv
// Keeps strobed or decimated I/Q samples and frames them into packets; kept beat visible 1 cycle later.
// Input ready is simply not-full of the output FIFO, so backpressure propagates with no combinational path.
module symbol_strobe_packer
   import symbol_packer_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 16
) (
   input  logic                         ce_clk,
   input  logic                         ce_rst,
   input  logic                         clear,
   input  logic                         mode,
   input  logic [CNT_W-1:0]             n,
   input  logic [CNT_W-1:0]             spp,
   input  logic                         eob_mode,
   input  logic                         sym_stb,
   input  logic [WIDTH-1:0]             i_tdata,
   input  logic                         i_tlast,
   input  logic                         i_tvalid,
   output logic                         i_tready,
   output logic [WIDTH-1:0]             o_tdata,
   output logic                         o_tlast,
   output logic                         o_tvalid,
   input  logic                         o_tready,
   output logic [clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]             drop_cnt
);

   logic [CNT_W-1:0] dcnt_q, dcnt_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;
   logic             eob_q, eob_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [CNT_W:0]   drop_sum;
   logic [CNT_W-1:0] spp_m1;
   logic             accept;
   logic             decim_hit;
   logic             keep;
   logic             last;
   logic             fifo_full;
   logic             fifo_empty;
   logic             wr_en;
   logic [WIDTH:0]   rd_dat;

   assign accept    = i_tvalid & i_tready;
   assign decim_hit = (n <= CNT_W'(1)) || (dcnt_q >= n - CNT_W'(1));
   assign keep      = (mode == MODE_STROBE) ? sym_stb : decim_hit;
   assign spp_m1    = (spp == '0) ? '0 : spp - CNT_W'(1);
   // The flag term lets an input tlast seen on a discarded beat close the next kept beat.
   assign last      = (pcnt_q == spp_m1) | (eob_mode & (eob_q | i_tlast));
   assign wr_en     = accept & keep & ~clear;
   assign drop_sum  = {1'b0, drop_q} + (CNT_W+1)'(fifo_level);

   always_comb begin
      dcnt_d = dcnt_q;
      pcnt_d = pcnt_q;
      eob_d  = eob_q;
      drop_d = drop_q;
      if (clear) begin
         dcnt_d = '0;
         pcnt_d = '0;
         eob_d  = 1'b0;
         drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end else if (accept) begin
         if (mode == MODE_DECIM) begin
            dcnt_d = decim_hit ? '0 : dcnt_q + CNT_W'(1);
         end
         if (keep) begin
            pcnt_d = last ? '0 : pcnt_q + CNT_W'(1);
            eob_d  = 1'b0;
         end else begin
            eob_d  = eob_q | i_tlast;
         end
      end
   end

   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         dcnt_q <= '0;
         pcnt_q <= '0;
         eob_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         dcnt_q <= dcnt_d;
         pcnt_q <= pcnt_d;
         eob_q  <= eob_d;
         drop_q <= drop_d;
      end
   end

   symbol_packer_fifo #(
      .DW    (WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .ce_clk   (ce_clk),
      .ce_rst   (ce_rst),
      .clear_i  (clear),
      .wr_en_i  (wr_en),
      .wr_dat_i ({last, i_tdata}),
      .rd_en_i  (o_tready),
      .rd_dat_o (rd_dat),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .level_o  (fifo_level)
   );

   assign i_tready = ~fifo_full;
   assign o_tvalid = ~fifo_empty;
   assign o_tdata  = rd_dat[WIDTH-1:0];
   assign o_tlast  = rd_dat[WIDTH];
   assign drop_cnt = drop_q;

endmodule
